// File: rtl/sr_excitation_driver.sv
// sr_excitation_driver
// Drives a bank of WIDTH SR flip-flops toward a requested target word.
// Only the bits that must change get a one-cycle Set or Reset pulse, worked
// out against a shadow copy of the bank, so S=R=1 can never be produced.
// Optional feature macro READBACK_CHECK_EN:
//   defined   - after the drive cycle the bank's Q readback is compared with
//               the target; a mismatch pulses err, reports the differing bits
//               and resyncs the shadow to what the bank really holds.
//   undefined - no readback stage, q_in is ignored, err/err_bits stay 0 and
//               the shadow simply takes the target.
module sr_excitation_driver #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   input  logic [WIDTH-1:0] tgt_data,
   output logic             tgt_ready,
   output logic [WIDTH-1:0] s_out,
   output logic [WIDTH-1:0] r_out,
   input  logic [WIDTH-1:0] q_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] err_bits
);

`ifdef READBACK_CHECK_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      RESP  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd3
   } state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] target;

`ifdef READBACK_CHECK_EN
   logic             err_q;
   logic [WIDTH-1:0] err_bits_q;

   assign err      = err_q;
   assign err_bits = err_bits_q;
`else
   logic unused_q_in;

   assign err         = 1'b0;
   assign err_bits    = '0;
   assign unused_q_in = ^q_in;
`endif

   // Transfer sequencer: accept a target, pulse the drive, optionally verify, report.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shadow    <= '0;
         target    <= '0;
         s_out     <= '0;
         r_out     <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         tgt_ready <= 1'b0;
`ifdef READBACK_CHECK_EN
         err_q      <= 1'b0;
         err_bits_q <= '0;
`endif
      end else begin
         s_out <= '0;
         r_out <= '0;
         done  <= 1'b0;
`ifdef READBACK_CHECK_EN
         err_q      <= 1'b0;
         err_bits_q <= '0;
`endif
         case (state)
            IDLE: begin
               if (tgt_ready && tgt_valid) begin
                  target    <= tgt_data;
                  s_out     <= tgt_data & ~shadow;
                  r_out     <= ~tgt_data & shadow;
                  state     <= DRIVE;
                  busy      <= 1'b1;
                  tgt_ready <= 1'b0;
               end else begin
                  tgt_ready <= 1'b1;
               end
            end
            DRIVE: begin
`ifdef READBACK_CHECK_EN
               state <= CHECK;
`else
               shadow <= target;
               done   <= 1'b1;
               state  <= RESP;
`endif
            end
`ifdef READBACK_CHECK_EN
            CHECK: begin
               if (q_in == target) begin
                  shadow <= target;
                  done   <= 1'b1;
               end else begin
                  shadow     <= q_in;
                  err_q      <= 1'b1;
                  err_bits_q <= q_in ^ target;
               end
               state <= RESP;
            end
`endif
            RESP: begin
               state     <= IDLE;
               busy      <= 1'b0;
               tgt_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               tgt_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/sr_excitation_driver.md
SR_EXCITATION_DRIVER -- requirements
Module: sr_excitation_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the width of the driven SR flip-flop bank in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port tgt_valid, input, 1 bit: the target word is offered.
REQ-005 The block SHALL have port tgt_data, input, WIDTH bits: the desired next state of the bank.
REQ-006 The block SHALL have port tgt_ready, output, 1 bit: the block can accept a target.
REQ-007 The block SHALL have port s_out, output, WIDTH bits: per-bit Set drive to the bank.
REQ-008 The block SHALL have port r_out, output, WIDTH bits: per-bit Reset drive to the bank.
REQ-009 The block SHALL have port q_in, input, WIDTH bits: Q readback from the bank.
REQ-010 The block SHALL have port busy, output, 1 bit: the block is in any state other than IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse on a successful write.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse on a readback mismatch.
REQ-013 The block SHALL have port err_bits, output, WIDTH bits: the mismatching bit mask, valid while err=1 and 0 otherwise.

Function
REQ-014 The block SHALL keep a WIDTH-bit shadow register holding the believed bank state.
REQ-015 The FSM SHALL have the states IDLE, DRIVE, CHECK and RESP; every state SHALL last exactly one cycle except IDLE.
REQ-016 tgt_ready SHALL be 1 only in IDLE; a transfer is accepted on a rising edge where tgt_valid=1 and tgt_ready=1, and the block SHALL then latch tgt_data and move to DRIVE.
REQ-017 On acceptance, the block SHALL register s_out = tgt_data AND NOT shadow and r_out = NOT tgt_data AND shadow.
REQ-018 The block SHALL never assert s_out[i] and r_out[i] together, so the invalid S=R=1 encoding is never produced.
REQ-019 s_out and r_out SHALL be nonzero only during DRIVE and SHALL be all-zero in every other state.
REQ-020 If the target equals shadow, the block SHALL still pass through DRIVE with all-zero drive; there is no shortcut.
REQ-021 DRIVE SHALL go to CHECK; the bank samples the drive on the rising edge that ends DRIVE.
REQ-022 In CHECK, the block SHALL compare q_in with the latched target; CHECK SHALL then go to RESP.
REQ-023 On a match in CHECK: shadow SHALL become the target and RESP SHALL pulse done=1.
REQ-024 On a mismatch in CHECK: shadow SHALL become q_in (resync), RESP SHALL pulse err=1, and err_bits SHALL equal q_in XOR target.
REQ-025 RESP SHALL go to IDLE; done and err SHALL never be 1 in the same cycle.
REQ-026 Latency SHALL be: accept at edge N, drive valid in cycle N+1, CHECK in cycle N+2, done/err in cycle N+3, tgt_ready=1 again in cycle N+4.
REQ-027 The block SHALL ignore tgt_valid while busy=1; tgt_data SHALL be sampled only on acceptance.

Reset
REQ-028 While rst=1, the block SHALL asynchronously force the state to IDLE, shadow to 0, s_out and r_out to 0, done, err and err_bits to 0, busy to 0, and tgt_ready to 0.
REQ-029 tgt_ready SHALL become 1 on the first rising edge after rst falls.
REQ-030 A reset mid-transfer SHALL abort the transfer with no done or err pulse; shadow=0 matches a bank power-up state of 0.

Configuration
REQ-031 With READBACK_CHECK_EN defined, the block SHALL provide the CHECK state, the err pulse, err_bits and the q_in resync exactly as specified in REQ-022 to REQ-024.
REQ-032 Without READBACK_CHECK_EN, the block SHALL omit CHECK so that DRIVE goes directly to RESP.
REQ-033 Without READBACK_CHECK_EN, the block SHALL ignore q_in, tie err and err_bits to 0, and always set shadow to the target; done SHALL then come in cycle N+2 and tgt_ready in cycle N+3.

Verification
REQ-034 Scenario 1: after reset (WIDTH=8), write 0xA5 with the bank model following the drive -> s_out=0xA5 and r_out=0x00 for one cycle, done at N+3, and shadow=0xA5.
REQ-035 Scenario 2: from 0xA5, write 0x3C -> s_out=0x18 and r_out=0x81 in DRIVE, never both 1 in any bit, then done.
REQ-036 Scenario 3: write 0x3C again -> DRIVE with s_out=r_out=0x00, then done at N+3.
REQ-037 Scenario 4 (with READBACK_CHECK_EN): bank model stuck bit 2 at 0, write 0xFF -> err=1, err_bits=0x04, shadow=0xFB; the next write of 0xFF drives s_out=0x04.
REQ-038 Scenario 5: assert rst during DRIVE -> s_out and r_out go to 0 immediately, no done or err pulse, and tgt_ready=1 one edge after rst falls.
REQ-039 Scenario 6: hold tgt_valid=1 with changing tgt_data through a whole transfer -> only the accepted word is written, with one acceptance per IDLE visit.
